// File: rtl/d_cache_responder_if.sv
// Request-side and main-memory-side bundles for d_cache_responder, plus shared opcode/size/status encodings.
`ifndef D_CACHE_NOP
`define D_CACHE_NOP      2'b00
`define D_CACHE_LOAD     2'b01
`define D_CACHE_STORE    2'b10
`define ONE_BYTE         3'b000
`define TWO_BYTE         3'b001
`define FOUR_BYTE        3'b010
`define D_CACHE_RESTING  2'b00
`define D_CACHE_WORKING  2'b01
`define D_CACHE_FINISHED 2'b10
`endif

interface d_cache_req_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int LEN        = 32
);
   logic [1:0]            cache_vis_signal;
   logic [ADDR_WIDTH-1:0] mem_vis_addr;
   logic [2:0]            data_type;
   logic [LEN-1:0]        cache_written_data;
   logic [LEN-1:0]        mem_data;
   logic [1:0]            d_cache_status;
   logic                  misalign_err;

   modport master (output cache_vis_signal, mem_vis_addr, data_type, cache_written_data,
                   input  mem_data, d_cache_status, misalign_err);
   modport slave  (input  cache_vis_signal, mem_vis_addr, data_type, cache_written_data,
                   output mem_data, d_cache_status, misalign_err);
endinterface

interface d_cache_mem_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int LEN        = 32
);
   logic                  main_mem_req;
   logic                  main_mem_we;
   logic [ADDR_WIDTH-1:0] main_mem_addr;
   logic [LEN-1:0]        main_mem_wdata;
   logic [LEN-1:0]        main_mem_rdata;
   logic                  main_mem_ready;

   modport master (output main_mem_req, main_mem_we, main_mem_addr, main_mem_wdata,
                   input  main_mem_rdata, main_mem_ready);
   modport slave  (input  main_mem_req, main_mem_we, main_mem_addr, main_mem_wdata,
                   output main_mem_rdata, main_mem_ready);
endinterface

// File: rtl/d_cache_responder.sv
// Direct-mapped write-back data cache: hits answer in the request cycle, misses stall via writeback/refill until main_mem_ready.
// Requests outside IDLE are ignored; DCACHE_STATS_EN adds hit_count/miss_count.
module d_cache_responder #(
   parameter int ADDR_WIDTH       = 17,
   parameter int LEN              = 32,
   parameter int CACHE_SIZE       = 16,
   parameter int CACHE_INDEX_SIZE = 4
) (
   input logic           clk,
   input logic           rst_n,
   d_cache_req_if.slave  req_bus,
   d_cache_mem_if.master mem_bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]   hit_count,
   output logic [31:0]   miss_count
`endif
);
   localparam int TAG_W = ADDR_WIDTH - CACHE_INDEX_SIZE - 2;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL, S_RESP} state_t;

   state_t                   state_q;
   logic [LEN-1:0]           data_q [CACHE_SIZE];
   logic [TAG_W-1:0]         tag_q  [CACHE_SIZE];
   logic [CACHE_SIZE-1:0]    valid_q, dirty_q;
   logic                     req_q, we_q, misalign_q;
   logic [ADDR_WIDTH-1:0]    mem_addr_q;
   logic [LEN-1:0]           mem_wdata_q, resp_q;
   logic [1:0]               status_q;
   logic                     lstore_q;
   logic [ADDR_WIDTH-1:0]    laddr_q;
   logic [2:0]               ltype_q;
   logic [LEN-1:0]           lwdata_q;

   function automatic logic [LEN-1:0] extract(input logic [LEN-1:0] w, input logic [1:0] off,
                                              input logic [2:0] ty);
      logic [LEN-1:0] r;
      r = '0;
      case (ty)
         `ONE_BYTE: r[7:0]  = w[{off, 3'b000} +: 8];
         `TWO_BYTE: r[15:0] = w[{off[1], 4'b0000} +: 16];
         default:   r       = w;
      endcase
      return r;
   endfunction

   function automatic logic [LEN-1:0] merge(input logic [LEN-1:0] w, input logic [LEN-1:0] d,
                                            input logic [1:0] off, input logic [2:0] ty);
      logic [LEN-1:0] r;
      r = w;
      case (ty)
         `ONE_BYTE: r[{off, 3'b000} +: 8]     = d[7:0];
         `TWO_BYTE: r[{off[1], 4'b0000} +: 16] = d[15:0];
         default:   r                          = d;
      endcase
      return r;
   endfunction

   logic [1:0]                  op;
   logic [ADDR_WIDTH-1:0]       addr;
   logic [2:0]                  ty;
   logic [CACHE_INDEX_SIZE-1:0] idx, lidx;
   logic [TAG_W-1:0]            tag, ltag;
   logic                        accept, aligned, hit, mem_done;

   assign op       = req_bus.cache_vis_signal;
   assign addr     = req_bus.mem_vis_addr;
   assign ty       = req_bus.data_type;
   assign idx      = addr[CACHE_INDEX_SIZE+1:2];
   assign tag      = addr[ADDR_WIDTH-1:CACHE_INDEX_SIZE+2];
   assign lidx     = laddr_q[CACHE_INDEX_SIZE+1:2];
   assign ltag     = laddr_q[ADDR_WIDTH-1:CACHE_INDEX_SIZE+2];
   assign accept   = (state_q == S_IDLE) && (op != `D_CACHE_NOP);
   assign aligned  = (ty == `ONE_BYTE) ? 1'b1 :
                     (ty == `TWO_BYTE) ? !addr[0] : (addr[1:0] == 2'b00);
   assign hit      = valid_q[idx] && (tag_q[idx] == tag);
   // ready only counts while our request is actually on the bus
   assign mem_done = req_q && mem_bus.main_mem_ready;

   always_comb begin
      req_bus.mem_data = resp_q;
      if (state_q == S_IDLE)
         req_bus.mem_data = (accept && aligned && hit && op == `D_CACHE_LOAD) ?
                            extract(data_q[idx], addr[1:0], ty) : '0;
   end

   assign req_bus.d_cache_status = status_q;
   assign req_bus.misalign_err   = misalign_q;
   assign mem_bus.main_mem_req   = req_q;
   assign mem_bus.main_mem_we    = we_q;
   assign mem_bus.main_mem_addr  = mem_addr_q;
   assign mem_bus.main_mem_wdata = mem_wdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         misalign_q  <= 1'b0;
         status_q    <= `D_CACHE_RESTING;
         resp_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         lstore_q    <= 1'b0;
         laddr_q     <= '0;
         ltype_q     <= '0;
         lwdata_q    <= '0;
`ifdef DCACHE_STATS_EN
         hit_count   <= '0;
         miss_count  <= '0;
`endif
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            S_IDLE: if (accept) begin
               if (!aligned) begin
                  misalign_q <= 1'b1;
               end else if (hit) begin
`ifdef DCACHE_STATS_EN
                  hit_count <= hit_count + 32'd1;
`endif
                  if (op == `D_CACHE_STORE) begin
                     data_q[idx]  <= merge(data_q[idx], req_bus.cache_written_data, addr[1:0], ty);
                     dirty_q[idx] <= 1'b1;
                  end
               end else begin
`ifdef DCACHE_STATS_EN
                  miss_count <= miss_count + 32'd1;
`endif
                  lstore_q <= (op == `D_CACHE_STORE);
                  laddr_q  <= addr;
                  ltype_q  <= ty;
                  lwdata_q <= req_bus.cache_written_data;
                  status_q <= `D_CACHE_WORKING;
                  req_q    <= 1'b1;
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state_q     <= S_WB;
                     we_q        <= 1'b1;
                     mem_addr_q  <= {tag_q[idx], idx, 2'b00};
                     mem_wdata_q <= data_q[idx];
                  end else begin
                     state_q    <= S_REFILL;
                     we_q       <= 1'b0;
                     mem_addr_q <= {tag, idx, 2'b00};
                  end
               end
            end
            S_WB: if (mem_done) begin
               // drop req for one cycle so the refill is a distinct transaction
               dirty_q[lidx] <= 1'b0;
               req_q         <= 1'b0;
               we_q          <= 1'b0;
               mem_addr_q    <= {ltag, lidx, 2'b00};
               state_q       <= S_REFILL;
            end
            S_REFILL: begin
               if (mem_done) begin
                  req_q         <= 1'b0;
                  valid_q[lidx] <= 1'b1;
                  tag_q[lidx]   <= ltag;
                  dirty_q[lidx] <= lstore_q;
                  data_q[lidx]  <= lstore_q ?
                                   merge(mem_bus.main_mem_rdata, lwdata_q, laddr_q[1:0], ltype_q) :
                                   mem_bus.main_mem_rdata;
                  resp_q        <= lstore_q ? '0 :
                                   extract(mem_bus.main_mem_rdata, laddr_q[1:0], ltype_q);
                  status_q      <= `D_CACHE_FINISHED;
                  state_q       <= S_RESP;
               end else begin
                  req_q <= 1'b1;
               end
            end
            S_RESP: begin
               resp_q   <= '0;
               status_q <= `D_CACHE_RESTING;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_d_cache_responder.sv
// Directed bench for d_cache_responder: a line-level cache model drives per-cycle expectations checked on the falling edge.
module tb_d_cache_responder;
   localparam int AW = 17;
   localparam int DW = 32;
   localparam logic [1:0] NOP = `D_CACHE_NOP, LD = `D_CACHE_LOAD, ST = `D_CACHE_STORE;
   localparam logic [2:0] B1 = `ONE_BYTE, B2 = `TWO_BYTE, B4 = `FOUR_BYTE;
   localparam logic [1:0] RESTING = 2'b00, WORKING = 2'b01, FINISHED = 2'b10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   d_cache_req_if #(.ADDR_WIDTH(AW), .LEN(DW)) rq ();
   d_cache_mem_if #(.ADDR_WIDTH(AW), .LEN(DW)) mm ();
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   d_cache_responder #(.ADDR_WIDTH(AW), .LEN(DW), .CACHE_SIZE(16), .CACHE_INDEX_SIZE(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_bus (rq),
      .mem_bus (mm)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   // cache model: one word per line, 16 lines
   logic        m_valid [16];
   logic        m_dirty [16];
   logic [10:0] m_tag   [16];
   logic [31:0] m_data  [16];
   int          m_hits, m_misses;

   logic        exp_chk, exp_req, exp_we, exp_misalign;
   logic [1:0]  exp_status;
   logic [31:0] exp_mem_data, exp_wdata;
   logic [16:0] exp_addr;
   logic [31:0] obs_data, obs_wb_data;
   logic [16:0] obs_wb_addr;
   logic        obs_mis;
   int          checks = 0, errors = 0, work_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_chk) begin
         chk("status", {30'd0, rq.d_cache_status}, {30'd0, exp_status});
         chk("mem_data", rq.mem_data, exp_mem_data);
         chk("misalign_err", {31'd0, rq.misalign_err}, {31'd0, exp_misalign});
         chk("main_mem_req", {31'd0, mm.main_mem_req}, {31'd0, exp_req});
         if (exp_req) begin
            chk("main_mem_we", {31'd0, mm.main_mem_we}, {31'd0, exp_we});
            chk("main_mem_addr", {15'd0, mm.main_mem_addr}, {15'd0, exp_addr});
            if (exp_we) chk("main_mem_wdata", mm.main_mem_wdata, exp_wdata);
         end
      end
      if (rq.d_cache_status === WORKING) work_cnt++;
   end

   function automatic logic [31:0] f_ext(input logic [31:0] w, input logic [16:0] a, input logic [2:0] t);
      int sh;
      if (t == B1) begin sh = int'(a[1:0]) * 8;  return (w >> sh) & 32'hFF;   end
      if (t == B2) begin sh = int'(a[1]) * 16;   return (w >> sh) & 32'hFFFF; end
      return w;
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [16:0] a, input logic [2:0] t);
      logic [31:0] m;
      int sh;
      if (t == B1)      begin sh = int'(a[1:0]) * 8; m = 32'hFF << sh;   end
      else if (t == B2) begin sh = int'(a[1]) * 16;  m = 32'hFFFF << sh; end
      else              begin sh = 0;                m = 32'hFFFF_FFFF;  end
      return (old & ~m) | ((d << sh) & m);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_phase(input int lat, input logic [31:0] rd);
      for (int k = 0; k <= lat; k++) begin
         mm.main_mem_ready = (k == lat);
         mm.main_mem_rdata = (k == lat) ? rd : 32'h0;
         tick();
      end
      mm.main_mem_ready = 1'b0;
      mm.main_mem_rdata = 32'h0;
   endtask

   task automatic do_access(input logic [1:0] op, input logic [16:0] a, input logic [2:0] t,
                            input logic [31:0] wd, input logic [31:0] rd, input int lat);
      int          idx;
      logic [10:0] tg;
      logic        ok, hit;
      idx = int'(a[5:2]);
      tg  = a[16:6];
      ok  = (t == B1) || (t == B2 && !a[0]) || (t != B1 && t != B2 && a[1:0] == 2'b00);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      rq.cache_vis_signal   = op;
      rq.mem_vis_addr       = a;
      rq.data_type          = t;
      rq.cache_written_data = wd;
      exp_status = RESTING; exp_req = 1'b0; exp_misalign = 1'b0;
      exp_mem_data = (ok && hit && op == LD) ? f_ext(m_data[idx], a, t) : 32'h0;
      #1 obs_data = rq.mem_data;
      tick();
      rq.cache_vis_signal = NOP;
      exp_mem_data = 32'h0;
      if (!ok) begin
         exp_misalign = 1'b1;
         #1 obs_mis = rq.misalign_err;
         tick();
         exp_misalign = 1'b0;
         return;
      end
      if (hit) begin
         m_hits++;
         if (op == ST) begin
            m_data[idx]  = f_merge(m_data[idx], wd, a, t);
            m_dirty[idx] = 1'b1;
         end
         return;
      end
      m_misses++;
      exp_status = WORKING;
      if (m_valid[idx] && m_dirty[idx]) begin
         exp_req = 1'b1; exp_we = 1'b1;
         exp_addr  = {m_tag[idx], a[5:2], 2'b00};
         exp_wdata = m_data[idx];
         #1 begin obs_wb_addr = mm.main_mem_addr; obs_wb_data = mm.main_mem_wdata; end
         mem_phase(lat, 32'h0);
         m_dirty[idx] = 1'b0;
         exp_req = 1'b0;
         tick();
      end
      exp_req = 1'b1; exp_we = 1'b0;
      exp_addr = {tg, a[5:2], 2'b00};
      mem_phase(lat, rd);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      if (op == ST) begin
         m_data[idx] = f_merge(rd, wd, a, t); m_dirty[idx] = 1'b1; exp_mem_data = 32'h0;
      end else begin
         m_data[idx] = rd; m_dirty[idx] = 1'b0; exp_mem_data = f_ext(rd, a, t);
      end
      exp_req = 1'b0; exp_status = FINISHED;
      #1 obs_data = rq.mem_data;
      tick();
      exp_status = RESTING; exp_mem_data = 32'h0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
      m_hits = 0; m_misses = 0;
   endtask

   initial begin
      exp_chk = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_misalign = 1'b0;
      exp_status = RESTING; exp_mem_data = 32'h0; exp_wdata = 32'h0; exp_addr = '0;
      rq.cache_vis_signal = NOP; rq.mem_vis_addr = '0; rq.data_type = B4; rq.cache_written_data = '0;
      mm.main_mem_ready = 1'b0; mm.main_mem_rdata = '0;
      model_reset();
      rst_n = 1'b0;
      tick();
      exp_chk = 1'b1;
      tick();
      rst_n = 1'b1;

      // cold load miss, 3-cycle memory latency
      work_cnt = 0;
      do_access(LD, 17'h0040, B4, 32'h0, 32'hDEADBEEF, 3);
      chk("miss_load_data", obs_data, 32'hDEADBEEF);
      chk("miss_working_cycles", work_cnt, 4);
      do_access(LD, 17'h0040, B4, 32'h0, 32'h0, 0);
      chk("hit_load_data", obs_data, 32'hDEADBEEF);

      do_access(ST, 17'h0042, B1, 32'h0000_00AA, 32'h0, 0);
      do_access(LD, 17'h0042, B2, 32'h0, 32'h0, 0);
      chk("hit_half_after_store", obs_data, 32'h0000DEAA);

      // dirty victim at index 0
      do_access(LD, 17'h0440, B4, 32'h0, 32'h12345678, 2);
      chk("wb_addr", {15'd0, obs_wb_addr}, 32'h0000_0040);
      chk("wb_data", obs_wb_data, 32'hDEAABEEF);
      chk("refill_data", obs_data, 32'h12345678);

      do_access(ST, 17'h0081, B2, 32'h0000_1234, 32'h0, 0);
      chk("misalign_pulse", {31'd0, obs_mis}, 32'd1);
      do_access(LD, 17'h0443, B1, 32'h0, 32'h0, 0);
      chk("hit_top_byte", obs_data, 32'h0000_0012);

      // store miss into a clean line, then dirty-victim store miss on the same index
      do_access(ST, 17'h004C, B4, 32'hA5A5A5A5, 32'h0, 0);
      do_access(LD, 17'h004C, B4, 32'h0, 32'h0, 0);
      chk("store_miss_word", obs_data, 32'hA5A5A5A5);
      do_access(ST, 17'h0C4E, B2, 32'h0000_BEEF, 32'hCAFEF00D, 1);
      chk("wb2_addr", {15'd0, obs_wb_addr}, 32'h0000_004C);
      chk("wb2_data", obs_wb_data, 32'hA5A5A5A5);
      do_access(LD, 17'h0C4C, B4, 32'h0, 32'h0, 0);
      chk("store_miss_merge", obs_data, 32'hBEEFF00D);

      // reset while the refill request is outstanding
      rq.cache_vis_signal = LD; rq.mem_vis_addr = 17'h0080; rq.data_type = B4;
      exp_status = RESTING; exp_req = 1'b0; exp_mem_data = 32'h0;
      tick();
      rq.cache_vis_signal = NOP;
      exp_status = WORKING; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 17'h0080;
      rst_n = 1'b0;
      tick();
      exp_status = RESTING; exp_req = 1'b0;
      chk("rst_req_drop", {31'd0, mm.main_mem_req}, 32'd0);
      chk("rst_status", {30'd0, rq.d_cache_status}, 32'd0);
      rst_n = 1'b1;
      model_reset();

      work_cnt = 0;
      do_access(LD, 17'h0080, B4, 32'h0, 32'h11223344, 3);
      chk("reload_misses", work_cnt, 4);
      chk("reload_data", obs_data, 32'h11223344);
      do_access(LD, 17'h0080, B1, 32'h0, 32'h0, 0);
      chk("hit_byte0", obs_data, 32'h0000_0044);
      do_access(LD, 17'h0082, B2, 32'h0, 32'h0, 0);
      chk("hit_upper_half", obs_data, 32'h0000_1122);
      do_access(ST, 17'h0081, B1, 32'h0000_0055, 32'h0, 0);
      do_access(LD, 17'h0082, B4, 32'h0, 32'h0, 0);
      chk("misalign_word", {31'd0, obs_mis}, 32'd1);
      tick();
      exp_chk = 1'b0;
`ifdef DCACHE_STATS_EN
      chk("hit_count_model", hit_count, m_hits);
      chk("miss_count_model", miss_count, m_misses);
      chk("hit_count", hit_count, 32'd3);
      chk("miss_count", miss_count, 32'd1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/d_cache_responder.md
Name: d_cache_responder

Overview:
Direct-mapped, write-back, write-allocate data cache. It is the responder on the memory-controller-to-cache interface: it receives cache_vis_signal, mem_vis_addr, data_type and cache_written_data, and returns mem_data and d_cache_status. Hits are answered combinationally in the request cycle. Misses run a writeback/refill sequence over a simple req/ready main-memory port.

Parameters:
ADDR_WIDTH, 17, byte address width
LEN, 32, data word / line width in bits
CACHE_SIZE, 16, number of lines (one word per line)
CACHE_INDEX_SIZE, 4, log2(CACHE_SIZE)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset: synchronous, active-low
cache_vis_signal  input  2  `D_CACHE_NOP / `D_CACHE_LOAD / `D_CACHE_STORE (defines.v)
mem_vis_addr  input  ADDR_WIDTH  byte address of the access
data_type  input  3  `ONE_BYTE / `TWO_BYTE / `FOUR_BYTE (defines.v)
cache_written_data  input  LEN  store data, right-justified
mem_data  output  LEN  load result, right-justified, zero-extended
d_cache_status  output  2  `D_CACHE_RESTING=00, `D_CACHE_WORKING=01, `D_CACHE_FINISHED=10
misalign_err  output  1  one-cycle pulse on a rejected misaligned request
main_mem_req  output  1  main-memory request, held until ready
main_mem_we  output  1  1 = writeback, 0 = refill
main_mem_addr  output  ADDR_WIDTH  word-aligned byte address ([1:0]=0)
main_mem_wdata  output  LEN  writeback data
main_mem_rdata  input  LEN  refill data, valid while main_mem_ready=1
main_mem_ready  input  1  one-cycle completion pulse

Behaviour:
- Address split: offset [1:0]; index [CACHE_INDEX_SIZE+1:2]; tag [ADDR_WIDTH-1:CACHE_INDEX_SIZE+2]. Per-line state: valid, dirty, tag, data.
- Reset (rst_n=0 at an edge): FSM goes to IDLE; all valid and dirty bits clear; main_mem_req=0, main_mem_we=0, misalign_err=0, d_cache_status=RESTING, mem_data=0. Reset mid-miss abandons the transfer; dirty data is lost by design.
- Requests are accepted only in IDLE (status RESTING) with cache_vis_signal != NOP. Requests in any other state are ignored.
- Alignment: TWO_BYTE needs addr[0]=0; FOUR_BYTE needs addr[1:0]=0. A misaligned request sets misalign_err=1 for the next cycle only, changes no state, and mem_data=0.
- Load hit: mem_data = selected bytes of the line, combinational in the request cycle. Status stays RESTING. Requestor samples at the following edge.
- Store hit: at the request edge, write the selected bytes into the line and set dirty. Status stays RESTING.
- Miss: the request is latched (op, addr, type, wdata).
  - Next state is WRITEBACK if the victim is valid and dirty, otherwise REFILL. Status is WORKING from the next cycle.
- WRITEBACK: main_mem_req=1, we=1, addr={victim tag, index, 2'b0}, wdata=line. On main_mem_ready: clear dirty, go to REFILL.
- REFILL: main_mem_req=1, we=0, addr={req tag, index, 2'b0}. On main_mem_ready, write the line with valid=1 and new tag:
  - load: dirty=0; mem_data register = extracted bytes.
  - store: merge the store bytes into rdata, dirty=1.
  - Go to RESPOND.
- RESPOND: status=FINISHED for exactly one cycle; mem_data holds the registered load result (0 for stores); then IDLE.
- main_mem_req deasserts in the cycle after ready. A new request is never issued in the same cycle as ready.
- Byte select: ONE_BYTE → byte[offset]. TWO_BYTE → halfword at offset[1]. FOUR_BYTE → whole word. Unused upper bits are 0.
- Stores modify only the selected byte lanes.

Optional Feature:
DCACHE_STATS_EN: adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
- Each accepted aligned request increments exactly one counter at its accept edge; counters wrap at 2^32.
- Without the macro, neither the ports nor the counters exist.

Test Plan:
- Reset, then LOAD FOUR_BYTE @0x0040, mem rdata=0xDEADBEEF with ready after 3 cycles → WORKING 4 cycles, FINISHED 1 cycle with mem_data=0xDEADBEEF; repeat load → hit, mem_data=0xDEADBEEF combinational, status RESTING.
- After the line above, STORE ONE_BYTE 0xAA @0x0042 (hit), then LOAD TWO_BYTE @0x0042 → mem_data=0x0000DEAA.
- LOAD @0x0440 (same index, dirty victim) → WRITEBACK with addr=0x0040, wdata=0xDEAABEEF, then REFILL addr=0x0440, then FINISHED.
- STORE TWO_BYTE @0x0081 → misalign_err=1 for one cycle, no main_mem_req, status stays RESTING.
- Assert rst_n=0 during REFILL (req high) → next cycle req=0, status RESTING; reload of the same address misses.
- DCACHE_STATS_EN: 1 miss, 3 hits, 1 misaligned → miss_count=1, hit_count=3.
